// File: rtl/falafel_lsu_arbiter_pkg.sv
// Shared types for the falafel LSU port arbiter: LSU request/response
// records, LSU opcodes and the arbiter FSM state encoding.
package falafel_lsu_arbiter_pkg;

  typedef logic [31:0] word_t;
  typedef logic [15:0] free_block_t;

  typedef enum logic [2:0] {
    LSU_OP_LOAD_WORD   = 3'd0,
    LSU_OP_STORE_WORD  = 3'd1,
    LSU_OP_LOAD_BLOCK  = 3'd2,
    LSU_OP_STORE_BLOCK = 3'd3,
    LSU_OP_LOCK        = 3'd4,
    LSU_OP_UNLOCK      = 3'd5
  } lsu_op_e;

  typedef struct packed {
    lsu_op_e     op;
    word_t       addr;
    word_t       wdata;
    free_block_t wblock;
  } lsu_req_t;

  typedef struct packed {
    word_t       rdata;
    free_block_t rblock;
  } lsu_rsp_t;

  localparam int unsigned NUM_LSU_REQ = 2;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_ISSUE    = 2'd1,
    ARB_WAIT_RSP = 2'd2,
    ARB_RESP     = 2'd3
  } arb_state_e;

endpackage

// File: rtl/falafel_rr_arbiter.sv
// Combinational round-robin pick: first set bit of req_mask_i searching
// upward from last_grant_i+1 (wrapping), as one-hot grant plus index.
module falafel_rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_mask_i,
  input  logic [IW-1:0] last_grant_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          grant_valid_o
);

  logic [IW-1:0] idx_c;

  always_comb begin
    grant_o       = '0;
    grant_idx_o   = '0;
    grant_valid_o = 1'b0;
    idx_c         = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx_c = IW'((32'(last_grant_i) + k) % N);
      if (!grant_valid_o && req_mask_i[idx_c]) begin
        grant_o[idx_c] = 1'b1;
        grant_idx_o    = idx_c;
        grant_valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/falafel_lsu_arbiter.sv
// Round-robin sharing of the single falafel LSU port with LOCK/UNLOCK
// exclusivity. Optional lock watchdog: FALAFEL_LSU_ARB_LOCK_WDT_EN.
module falafel_lsu_arbiter
  import falafel_lsu_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ      = NUM_LSU_REQ,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  lsu_req_t                   req_i [NUM_REQ],
  output logic [NUM_REQ-1:0]         rsp_valid_o,
  output lsu_rsp_t                   rsp_o,
  output logic                       lsu_req_valid_o,
  input  logic                       lsu_req_ready_i,
  output lsu_req_t                   lsu_req_o,
  input  logic                       lsu_rsp_valid_i,
  input  lsu_rsp_t                   lsu_rsp_i,
  output logic                       lock_held_o,
  output logic [$clog2(NUM_REQ)-1:0] lock_owner_o,
  output logic                       lock_timeout_o,
  output arb_state_e                 state_o
);

  localparam int unsigned IW = $clog2(NUM_REQ);

  arb_state_e           state_q;
  logic [IW-1:0]        last_grant_q;
  logic [IW-1:0]        owner_q;
  lsu_req_t             lsu_req_q;
  logic                 lsu_req_valid_q;
  lsu_rsp_t             rsp_q;
  logic [NUM_REQ-1:0]   rsp_valid_q;
  logic                 lock_held_q;
  logic [IW-1:0]        lock_owner_q;
  logic                 wdt_expire;

  logic [NUM_REQ-1:0]   elig;
  logic [NUM_REQ-1:0]   grant;
  logic [IW-1:0]        grant_idx;
  logic                 grant_valid;

  // Handshakes: a transfer happens on a clock edge where valid and ready are
  // both 1; valid is held with its payload stable until then. req_ready_o is
  // combinational so acceptance lands in the IDLE cycle itself.
  assign elig = lock_held_q ? (req_valid_i & (NUM_REQ'(1) << lock_owner_q))
                            : req_valid_i;

  falafel_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_mask_i    (elig),
    .last_grant_i  (last_grant_q),
    .grant_o       (grant),
    .grant_idx_o   (grant_idx),
    .grant_valid_o (grant_valid)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= ARB_IDLE;
      last_grant_q    <= IW'(NUM_REQ - 1);
      owner_q         <= '0;
      lsu_req_q       <= '0;
      lsu_req_valid_q <= 1'b0;
      rsp_q           <= '0;
      rsp_valid_q     <= '0;
      lock_held_q     <= 1'b0;
      lock_owner_q    <= '0;
    end else begin
      rsp_valid_q <= '0;
      case (state_q)
        ARB_IDLE: begin
          if (grant_valid) begin
            lsu_req_q       <= req_i[grant_idx];
            last_grant_q    <= grant_idx;
            owner_q         <= grant_idx;
            lsu_req_valid_q <= 1'b1;
            state_q         <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (lsu_req_ready_i) begin
            lsu_req_valid_q <= 1'b0;
            state_q         <= ARB_WAIT_RSP;
          end
        end
        ARB_WAIT_RSP: begin
          if (lsu_rsp_valid_i) begin
            rsp_q       <= lsu_rsp_i;
            rsp_valid_q <= NUM_REQ'(1) << owner_q;
            state_q     <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          // Lock state only changes once the LSU has completed the op.
          case (lsu_req_q.op)
            LSU_OP_LOCK: begin
              lock_held_q  <= 1'b1;
              lock_owner_q <= owner_q;
            end
            LSU_OP_UNLOCK: begin
              if (lock_held_q && (lock_owner_q == owner_q)) lock_held_q <= 1'b0;
            end
            default: ;
          endcase
          state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
      if (wdt_expire) lock_held_q <= 1'b0;
    end
  end

`ifdef FALAFEL_LSU_ARB_LOCK_WDT_EN
  localparam int unsigned WDT_W = $clog2(LOCK_TIMEOUT + 1);

  logic [WDT_W-1:0] wdt_cnt_q;
  logic             lock_timeout_q;

  assign wdt_expire = lock_held_q && (wdt_cnt_q == WDT_W'(LOCK_TIMEOUT));

  // Counts only idle cycles under lock, i.e. time the owner leaves the port unused.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wdt_cnt_q      <= '0;
      lock_timeout_q <= 1'b0;
    end else begin
      if (!lock_held_q || wdt_expire) begin
        wdt_cnt_q <= '0;
      end else if (state_q == ARB_IDLE) begin
        wdt_cnt_q <= wdt_cnt_q + 1'b1;
      end
      if (wdt_expire) lock_timeout_q <= 1'b1;
    end
  end

  assign lock_timeout_o = lock_timeout_q;
`else
  logic unused_lock_timeout;
  assign unused_lock_timeout = ^32'(LOCK_TIMEOUT);
  assign wdt_expire          = 1'b0;
  assign lock_timeout_o      = 1'b0;
`endif

  assign req_ready_o     = (rst_ni && (state_q == ARB_IDLE)) ? grant : '0;
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_o           = rsp_q;
  assign lsu_req_valid_o = lsu_req_valid_q;
  assign lsu_req_o       = lsu_req_q;
  assign lock_held_o     = lock_held_q;
  assign lock_owner_o    = lock_owner_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_falafel_lsu_arbiter.sv
// Self-checking bench for falafel_lsu_arbiter: directed scenarios, then
// randomized traffic against a round-robin/lock reference model.
`timescale 1ns/1ps
module tb_falafel_lsu_arbiter;
  import falafel_lsu_arbiter_pkg::*;

  localparam int unsigned N   = 2;
  localparam int unsigned TMO = 16;
  localparam int unsigned IW  = $clog2(N);

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [N-1:0]  req_valid_i;
  logic [N-1:0]  req_ready_o;
  lsu_req_t      req_i [N];
  logic [N-1:0]  rsp_valid_o;
  lsu_rsp_t      rsp_o;
  logic          lsu_req_valid_o;
  logic          lsu_req_ready_i;
  lsu_req_t      lsu_req_o;
  logic          lsu_rsp_valid_i;
  lsu_rsp_t      lsu_rsp_i;
  logic          lock_held_o;
  logic [IW-1:0] lock_owner_o;
  logic          lock_timeout_o;
  arb_state_e    state_o;

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  falafel_lsu_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(TMO)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_i           (req_i),
    .rsp_valid_o     (rsp_valid_o),
    .rsp_o           (rsp_o),
    .lsu_req_valid_o (lsu_req_valid_o),
    .lsu_req_ready_i (lsu_req_ready_i),
    .lsu_req_o       (lsu_req_o),
    .lsu_rsp_valid_i (lsu_rsp_valid_i),
    .lsu_rsp_i       (lsu_rsp_i),
    .lock_held_o     (lock_held_o),
    .lock_owner_o    (lock_owner_o),
    .lock_timeout_o  (lock_timeout_o),
    .state_o         (state_o)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [127:0] exp_q[$];
  int       m_last;
  bit       m_held;
  int       m_owner;
  lsu_rsp_t m_rsp;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int exp_grant();
    for (int k = 1; k <= int'(N); k++) begin
      int c;
      c = (m_last + k) % int'(N);
      if (req_valid_i[c] && (!m_held || c == m_owner)) return c;
    end
    return -1;
  endfunction

  function automatic lsu_op_e rand_op();
`ifdef FALAFEL_LSU_ARB_LOCK_WDT_EN
    return lsu_op_e'($urandom_range(0, 3));
`else
    return lsu_op_e'($urandom_range(0, 5));
`endif
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int i, input lsu_op_e op);
    req_i[i].op     = op;
    req_i[i].addr   = $urandom;
    req_i[i].wdata  = $urandom;
    req_i[i].wblock = 16'($urandom);
    req_valid_i[i]  = 1'b1;
  endtask

  // One full transaction, from the IDLE cycle to the IDLE cycle after RESP.
  task automatic serve(input int stall, input int rdly, input word_t rdata,
                       input bit rearm, input lsu_op_e next_op);
    int         g;
    int         waited;
    logic [N-1:0] exp_mask;
    lsu_req_t   r;
    lsu_rsp_t   d;
    g        = exp_grant();
    exp_mask = (g < 0) ? '0 : (N'(1) << g);
    waited   = 0;
    @(negedge clk_i);
    chk("lock_held", 128'(lock_held_o), 128'(m_held));
    if (m_held) chk("lock_owner", 128'(lock_owner_o), 128'(m_owner));
    while (req_ready_o == '0 && waited < 8) begin
      tick();
      @(negedge clk_i);
      waited++;
    end
    chk("grant", 128'(req_ready_o), 128'(exp_mask));
    chk("accept_latency", 128'(waited), 128'(0));
    if (g < 0 || req_ready_o == '0) return;
    r = req_i[g];
    exp_q.push_back(128'(r));
    m_last = g;
    tick();
    if (rearm) set_req(g, next_op);
    else req_valid_i[g] = 1'b0;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk_i);
      chk("issue_valid", 128'(lsu_req_valid_o), 128'(1));
      chk("issue_hold", 128'(lsu_req_o), exp_q[0]);
      chk("no_reaccept", 128'(req_ready_o), 128'(0));
      tick();
    end
    lsu_req_ready_i = 1'b1;
    @(negedge clk_i);
    chk("issue_valid", 128'(lsu_req_valid_o), 128'(1));
    chk("lsu_req", 128'(lsu_req_o), exp_q.pop_front());
    tick();
    lsu_req_ready_i = 1'b0;
    for (int i = 0; i < rdly; i++) begin
      @(negedge clk_i);
      chk("no_early_rsp", 128'(rsp_valid_o), 128'(0));
      tick();
    end
    d.rdata         = rdata;
    d.rblock        = 16'($urandom);
    lsu_rsp_i       = d;
    lsu_rsp_valid_i = 1'b1;
    @(negedge clk_i);
    chk("lsu_valid_dropped", 128'(lsu_req_valid_o), 128'(0));
    tick();
    lsu_rsp_valid_i = 1'b0;
    @(negedge clk_i);
    chk("rsp_valid", 128'(rsp_valid_o), 128'(N'(1) << g));
    chk("rsp_data", 128'(rsp_o), 128'(d));
    m_rsp = d;
    if (r.op == LSU_OP_LOCK) begin
      m_held  = 1'b1;
      m_owner = g;
    end else if (r.op == LSU_OP_UNLOCK && m_held && m_owner == g) begin
      m_held = 1'b0;
    end
    tick();
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int ready_seen;
    int c;
    rst_ni          = 1'b0;
    req_valid_i     = '0;
    lsu_req_ready_i = 1'b0;
    lsu_rsp_valid_i = 1'b0;
    lsu_rsp_i       = '0;
    for (int i = 0; i < int'(N); i++) req_i[i] = '0;
    m_last  = N - 1;
    m_held  = 1'b0;
    m_owner = 0;
    m_rsp   = '0;

    // Reset values, with a request already pending.
    set_req(0, LSU_OP_LOAD_WORD);
    repeat (3) tick();
    @(negedge clk_i);
    chk("rst_req_ready", 128'(req_ready_o), 128'(0));
    chk("rst_rsp_valid", 128'(rsp_valid_o), 128'(0));
    chk("rst_lsu_valid", 128'(lsu_req_valid_o), 128'(0));
    chk("rst_lsu_req", 128'(lsu_req_o), 128'(0));
    chk("rst_rsp", 128'(rsp_o), 128'(0));
    chk("rst_lock_held", 128'(lock_held_o), 128'(0));
    chk("rst_lock_owner", 128'(lock_owner_o), 128'(0));
    chk("rst_lock_timeout", 128'(lock_timeout_o), 128'(0));
    chk("rst_state", 128'(state_o), 128'(ARB_IDLE));
    req_valid_i = '0;
    tick();
    rst_ni = 1'b1;
    tick();

    // Single requester, minimum latency.
    set_req(0, LSU_OP_LOAD_WORD);
    req_i[0].addr = 32'h1000;
    serve(0, 0, 32'hDEAD, 1'b0, LSU_OP_LOAD_WORD);
    chk("single_rdata", 128'(rsp_o.rdata), 128'(32'hDEAD));

    // Fairness: both continuously requesting, then drained.
    set_req(0, LSU_OP_LOAD_WORD);
    set_req(1, LSU_OP_STORE_WORD);
    for (int i = 0; i < 6; i++) serve(0, 0, $urandom, (i < 4), LSU_OP_LOAD_WORD);

    // LSU backpressure with the other requester waiting.
    set_req(0, LSU_OP_STORE_WORD);
    set_req(1, LSU_OP_LOAD_BLOCK);
    serve(5, 2, $urandom, 1'b0, LSU_OP_LOAD_WORD);
    serve(0, 1, $urandom, 1'b0, LSU_OP_LOAD_WORD);

    // Stray LSU response while idle is ignored.
    lsu_rsp_i       = '{rdata: $urandom, rblock: 16'($urandom)};
    lsu_rsp_valid_i = 1'b1;
    tick();
    lsu_rsp_valid_i = 1'b0;
    @(negedge clk_i);
    chk("stray_rsp_valid", 128'(rsp_valid_o), 128'(0));
    chk("stray_rsp_data", 128'(rsp_o), 128'(m_rsp));
    chk("stray_state", 128'(state_o), 128'(ARB_IDLE));
    tick();

    // Lock exclusion: requester 1 locks, requester 0 starves until UNLOCK.
    set_req(1, LSU_OP_LOCK);
    serve(0, 0, $urandom, 1'b0, LSU_OP_LOAD_WORD);
    set_req(0, LSU_OP_LOAD_WORD);
`ifndef FALAFEL_LSU_ARB_LOCK_WDT_EN
    ready_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (req_ready_o != '0) ready_seen++;
      tick();
    end
    chk("locked_stall", 128'(ready_seen), 128'(0));
    chk("lock_kept", 128'(lock_held_o), 128'(1));
    chk("no_wdt", 128'(lock_timeout_o), 128'(0));
`endif
    set_req(1, LSU_OP_STORE_WORD);
    serve(0, 0, $urandom, 1'b1, LSU_OP_LOAD_BLOCK);
    serve(1, 0, $urandom, 1'b1, LSU_OP_UNLOCK);
    serve(0, 1, $urandom, 1'b0, LSU_OP_LOAD_WORD);
    serve(0, 0, $urandom, 1'b0, LSU_OP_LOAD_WORD);

    // Reset in WAIT_RSP with the lock held.
    set_req(1, LSU_OP_LOCK);
    serve(0, 0, $urandom, 1'b0, LSU_OP_LOAD_WORD);
    set_req(1, LSU_OP_LOAD_WORD);
    @(negedge clk_i);
    chk("pre_rst_grant", 128'(req_ready_o), 128'(2'b10));
    tick();
    req_valid_i[1]  = 1'b0;
    lsu_req_ready_i = 1'b1;
    tick();
    lsu_req_ready_i = 1'b0;
    set_req(0, LSU_OP_LOAD_WORD);
    set_req(1, LSU_OP_STORE_WORD);
    @(negedge clk_i);
    chk("pre_rst_state", 128'(state_o), 128'(ARB_WAIT_RSP));
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_lock_held", 128'(lock_held_o), 128'(0));
    chk("mid_rst_req_ready", 128'(req_ready_o), 128'(0));
    chk("mid_rst_lsu_valid", 128'(lsu_req_valid_o), 128'(0));
    chk("mid_rst_lsu_req", 128'(lsu_req_o), 128'(0));
    chk("mid_rst_rsp", 128'(rsp_o), 128'(0));
    chk("mid_rst_state", 128'(state_o), 128'(ARB_IDLE));
    m_last  = N - 1;
    m_held  = 1'b0;
    m_owner = 0;
    m_rsp   = '0;
    tick();
    rst_ni = 1'b1;
    serve(0, 0, $urandom, 1'b0, LSU_OP_LOAD_WORD);
    serve(0, 0, $urandom, 1'b0, LSU_OP_LOAD_WORD);

`ifdef FALAFEL_LSU_ARB_LOCK_WDT_EN
    // Watchdog: owner locks and then goes quiet.
    set_req(0, LSU_OP_LOCK);
    serve(0, 0, $urandom, 1'b0, LSU_OP_LOAD_WORD);
    c = 0;
    @(negedge clk_i);
    while (!lock_timeout_o && c < 40) begin
      tick();
      @(negedge clk_i);
      c++;
    end
    chk("wdt_latency_ok", 128'(c >= int'(TMO) && c <= int'(TMO) + 2), 128'(1));
    chk("wdt_flag", 128'(lock_timeout_o), 128'(1));
    chk("wdt_released", 128'(lock_held_o), 128'(0));
    m_held = 1'b0;
    tick();
    set_req(1, LSU_OP_LOAD_WORD);
    serve(0, 0, $urandom, 1'b0, LSU_OP_LOAD_WORD);
    @(negedge clk_i);
    chk("wdt_sticky", 128'(lock_timeout_o), 128'(1));
    tick();
`else
    c = 0;
`endif

    // Randomized traffic.
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < int'(N); i++)
        if (!req_valid_i[i] && $urandom_range(0, 1) == 1) set_req(i, rand_op());
      if (m_held && !req_valid_i[m_owner]) set_req(m_owner, rand_op());
      if (req_valid_i == '0) set_req($urandom_range(0, N - 1), rand_op());
      serve($urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'b0, LSU_OP_LOAD_WORD);
    end
    while (req_valid_i != '0 && c < 100) begin
      if (m_held && !req_valid_i[m_owner]) set_req(m_owner, LSU_OP_UNLOCK);
      serve(0, 0, $urandom, 1'b0, LSU_OP_LOAD_WORD);
      c++;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/falafel_lsu_arbiter.md
# falafel_lsu_arbiter

Shares the single falafel LSU port between N requesters (allocator FSM, free FSM, register-access path). Arbitration is round-robin, with one outstanding LSU transaction at a time. It honours the LSU_OP_LOCK/LSU_OP_UNLOCK protocol: a requester that locks the free list owns the LSU exclusively until it unlocks. It sits between the core FSMs and the LSU, and all traffic passes through it.

## Interface
- NUM_REQ, 2: number of requesters, 2..8.
- LOCK_TIMEOUT, 1024: watchdog limit in cycles. Used only with FALAFEL_LSU_ARB_LOCK_WDT_EN.
- clk_i  in  1  clock. The block uses this one clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  NUM_REQ  per-requester request valid. Held stable until req_ready_o.
- req_ready_o  out  NUM_REQ  one-hot acceptance pulse.
- req_i  in  NUM_REQ x lsu_req_t  per-requester {op, addr, wdata (word_t), wblock (free_block_t)}.
- rsp_valid_o  out  NUM_REQ  one-hot response pulse to the owner.
- rsp_o  out  lsu_rsp_t  {rdata (word_t), rblock (free_block_t)}. Shared across requesters and qualified by rsp_valid_o.
- lsu_req_valid_o  out  1  request to LSU.
- lsu_req_ready_i  in  1  LSU accepts.
- lsu_req_o  out  lsu_req_t  captured request.
- lsu_rsp_valid_i  in  1  LSU completion. Exactly one per accepted op, all op types included.
- lsu_rsp_i  in  lsu_rsp_t  LSU read data.
- lock_held_o  out  1  lock currently owned.
- lock_owner_o  out  $clog2(NUM_REQ)  owner index. Valid while lock_held_o=1.
- lock_timeout_o  out  1  sticky watchdog flag. Tied 0 when the watchdog is compiled out.

## Operation
- States:
  - IDLE: choose a grant.
  - ISSUE: drive lsu_req_valid_o until lsu_req_ready_i.
  - WAIT_RSP: wait for lsu_rsp_valid_i.
  - RESP: pulse rsp_valid_o[owner] for 1 cycle, then go to IDLE.
- Eligibility in IDLE:
  - Unlocked: every requester with req_valid_i is eligible.
  - Locked: only lock_owner is eligible. Other valid requests stall with req_ready_o=0.
- Round-robin: search starts at last_grant+1 mod NUM_REQ. last_grant resets to NUM_REQ-1, so requester 0 wins first.
- Acceptance, in the IDLE cycle with at least one eligible request:
  - req_ready_o[g]=1.
  - req_i[g] is captured into lsu_req_o.
  - last_grant←g.
  - Next state is ISSUE.
- Lock effects are applied in RESP, i.e. after the LSU completes:
  - LOCK: lock_held←1, lock_owner←g.
  - UNLOCK by the owner: lock_held←0.
  - UNLOCK while unlocked: forwarded, no state change.
  - LOCK by the current owner: forwarded, lock stays held.
- rsp_o is registered from lsu_rsp_i on lsu_rsp_valid_i and held until the next capture.
- lsu_rsp_valid_i outside WAIT_RSP is a protocol error. It is ignored.

## Timing
- Reset values:
  - All outputs 0: req_ready_o, rsp_valid_o, lsu_req_valid_o, lsu_req_o, rsp_o, lock_held_o, lock_owner_o, lock_timeout_o.
  - State IDLE, last_grant=NUM_REQ-1, watchdog counter 0.
- Minimum latency, with LSU ready immediately and responding the cycle after acceptance:
  - cycle 0: req_ready_o.
  - cycle 1: lsu_req_valid_o and lsu_req_ready_i.
  - cycle 2: lsu_rsp_valid_i.
  - cycle 3: rsp_valid_o.
  - cycle 4: IDLE, which can accept again. Throughput is one op per 4 cycles.
- lsu_req_o is stable while lsu_req_valid_o=1. The request is never withdrawn.
- Requests arriving in the RESP cycle are considered in the following IDLE cycle.
- A requester may assert req_valid_i in the same cycle its rsp_valid_o pulses.
- Asserting rst_ni mid-transaction returns the block to reset state immediately. The LSU shares rst_ni, so no orphaned response is expected.

## Configuration
- FALAFEL_LSU_ARB_LOCK_WDT_EN, when defined:
  - A counter increments on every cycle with lock_held=1 and in IDLE, and clears when the lock is released.
  - When the counter reaches LOCK_TIMEOUT, the lock is force-released and lock_timeout_o is set sticky until reset.
- Without the macro, no counter exists, the lock is held indefinitely, and lock_timeout_o=0.

## Structure
- Additions to falafel_pkg:
  - lsu_req_t {lsu_op_e op; word_t addr; word_t wdata; free_block_t wblock}.
  - lsu_rsp_t {word_t rdata; free_block_t rblock}.
  - NUM_LSU_REQ=2 default.
- One sub-module, falafel_rr_arbiter: combinational round-robin pick from a request mask and the last_grant pointer, outputting a one-hot grant and its index. The FSM owns the pointer register.

## Test plan
- Single requester: req 0 issues LOAD_WORD at addr 0x1000, LSU returns 0xDEAD → req_ready_o=01 at cycle 0, lsu_req_o.addr=0x1000, rsp_valid_o=01 with rsp_o.rdata=0xDEAD at cycle 3.
- Fairness: reqs 0 and 1 both request continuously, 6 ops → grant order 0,1,0,1,0,1.
- Lock exclusion:
  - req 1 issues LOCK, then req 0 and req 1 both request → only req 1 is served until its UNLOCK response.
  - lock_held_o=1 and lock_owner_o=1 throughout.
  - req 0 is granted in the first IDLE cycle after the UNLOCK.
- LSU backpressure: lsu_req_ready_i held low 5 cycles → lsu_req_valid_o stays 1 and lsu_req_o is unchanged, with no second req_ready_o.
- Reset mid-op: rst_ni low while in WAIT_RSP with the lock held → all outputs 0 and lock_held_o=0; next request goes to requester 0 first.
- Watchdog (macro on, LOCK_TIMEOUT=16): owner locks, then goes idle 16 cycles → lock_timeout_o=1 and lock_held_o=0, and the other requester is then served.
